// File: rtl/aq_gemac_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aq_gemac_rx_ctrl
// Brief    : GEMAC receive frame controller. Finds preamble/SFD, sequences the
//            CRC checker, forwards frame bytes and reports end-of-frame status.
//            Optional macro AQ_GEMAC_RX_STRIP_FCS_EN withholds the 4 FCS bytes.
// Revision : 1.0 - initial release
// ============================================================================
module aq_gemac_rx_ctrl #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int PRE_MAX = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RXD,
    input  logic        RX_DV,
    input  logic        RX_ER,
    output logic [7:0]  CRC_DATA,
    output logic        CRC_INIT,
    output logic        CRC_ENABLE,
    input  logic        CRC_ERR,
    output logic [7:0]  DOUT,
    output logic        DOUT_VALID,
    output logic        DOUT_SOP,
    output logic        STATUS_VALID,
    output logic [15:0] STATUS_LEN,
    output logic        STATUS_CRC_ERR,
    output logic        STATUS_RUNT,
    output logic        STATUS_LONG,
    output logic        STATUS_RXER,
    output logic        STATUS_GOOD
);
    localparam logic [15:0] c_min_len = 16'(MIN_LEN);
    localparam logic [15:0] c_max_len = 16'(MAX_LEN);
    localparam logic [7:0]  c_pre_max = 8'(PRE_MAX);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_DATA     = 3'd2,
        S_STATUS   = 3'd3,
        S_DROP     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  rxd_q;
    logic        dv_q, er_q;
    logic [7:0]  pre_q, pre_d;
    logic [15:0] len_q, len_d;
    logic        rxer_acc_q, rxer_acc_d;
    logic        sop_arm_q, sop_arm_d;
    logic [7:0]  dout_q, dout_d;
    logic        dout_valid_q, dout_valid_d;
    logic        dout_sop_q, dout_sop_d;
    logic        stat_valid_q, stat_valid_d;
    logic [15:0] stat_len_q, stat_len_d;
    logic        stat_crc_q, stat_crc_d;
    logic        stat_runt_q, stat_runt_d;
    logic        stat_long_q, stat_long_d;
    logic        stat_rxer_q, stat_rxer_d;
    logic        stat_good_q, stat_good_d;
`ifdef AQ_GEMAC_RX_STRIP_FCS_EN
    logic [3:0][7:0] dl_q, dl_d;
    logic [2:0]      fill_q, fill_d;
`endif

    assign CRC_DATA   = rxd_q;
    assign CRC_ENABLE = (state_q == S_DATA) & dv_q;
    assign CRC_INIT   = (state_q == S_PREAMBLE) & dv_q & (rxd_q == 8'hD5);

    always_comb begin
        state_d      = state_q;
        pre_d        = pre_q;
        len_d        = len_q;
        rxer_acc_d   = rxer_acc_q;
        sop_arm_d    = sop_arm_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        dout_sop_d   = 1'b0;
        stat_valid_d = 1'b0;
        stat_len_d   = stat_len_q;
        stat_crc_d   = stat_crc_q;
        stat_runt_d  = stat_runt_q;
        stat_long_d  = stat_long_q;
        stat_rxer_d  = stat_rxer_q;
        stat_good_d  = stat_good_q;
`ifdef AQ_GEMAC_RX_STRIP_FCS_EN
        dl_d         = dl_q;
        fill_d       = fill_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (dv_q) begin
                    if (rxd_q == 8'h55) begin
                        state_d = S_PREAMBLE;
                        pre_d   = 8'd1;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_PREAMBLE: begin
                if (!dv_q) begin
                    state_d = S_IDLE;
                end else if (rxd_q == 8'h55) begin
                    // pre_q already counts this byte's predecessors; one more overflows
                    if (pre_q >= c_pre_max) state_d = S_DROP;
                    else                    pre_d   = pre_q + 8'd1;
                end else if (rxd_q == 8'hD5) begin
                    state_d    = S_DATA;
                    len_d      = 16'h0000;
                    rxer_acc_d = 1'b0;
                    sop_arm_d  = 1'b1;
`ifdef AQ_GEMAC_RX_STRIP_FCS_EN
                    fill_d     = 3'd0;
`endif
                end else begin
                    state_d = S_DROP;
                end
            end
            S_DATA: begin
                if (dv_q) begin
                    if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
                    rxer_acc_d = rxer_acc_q | er_q;
`ifdef AQ_GEMAC_RX_STRIP_FCS_EN
                    // A byte leaves only when four newer bytes sit behind it,
                    // so the trailing FCS is never emitted.
                    dl_d = {dl_q[2:0], rxd_q};
                    if (fill_q == 3'd4) begin
                        dout_d       = dl_q[3];
                        dout_valid_d = 1'b1;
                        dout_sop_d   = sop_arm_q;
                        sop_arm_d    = 1'b0;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
`else
                    dout_d       = rxd_q;
                    dout_valid_d = 1'b1;
                    dout_sop_d   = sop_arm_q;
                    sop_arm_d    = 1'b0;
`endif
                end else begin
                    // Checker output already covers the final byte here.
                    state_d      = S_STATUS;
                    stat_valid_d = 1'b1;
                    stat_len_d   = len_q;
                    stat_crc_d   = CRC_ERR;
                    stat_runt_d  = len_q < c_min_len;
                    stat_long_d  = len_q > c_max_len;
                    stat_rxer_d  = rxer_acc_q;
                    stat_good_d  = !(CRC_ERR | (len_q < c_min_len) |
                                     (len_q > c_max_len) | rxer_acc_q);
`ifdef AQ_GEMAC_RX_STRIP_FCS_EN
                    fill_d       = 3'd0;
`endif
                end
            end
            S_STATUS: begin
                state_d = dv_q ? S_DROP : S_IDLE;
            end
            S_DROP: begin
                if (!dv_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            rxd_q        <= 8'h00;
            dv_q         <= 1'b0;
            er_q         <= 1'b0;
            pre_q        <= 8'h00;
            len_q        <= 16'h0000;
            rxer_acc_q   <= 1'b0;
            sop_arm_q    <= 1'b0;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_len_q   <= 16'h0000;
            stat_crc_q   <= 1'b0;
            stat_runt_q  <= 1'b0;
            stat_long_q  <= 1'b0;
            stat_rxer_q  <= 1'b0;
            stat_good_q  <= 1'b0;
`ifdef AQ_GEMAC_RX_STRIP_FCS_EN
            dl_q         <= '0;
            fill_q       <= 3'd0;
`endif
        end else begin
            state_q      <= state_d;
            rxd_q        <= RXD;
            dv_q         <= RX_DV;
            er_q         <= RX_ER;
            pre_q        <= pre_d;
            len_q        <= len_d;
            rxer_acc_q   <= rxer_acc_d;
            sop_arm_q    <= sop_arm_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_sop_q   <= dout_sop_d;
            stat_valid_q <= stat_valid_d;
            stat_len_q   <= stat_len_d;
            stat_crc_q   <= stat_crc_d;
            stat_runt_q  <= stat_runt_d;
            stat_long_q  <= stat_long_d;
            stat_rxer_q  <= stat_rxer_d;
            stat_good_q  <= stat_good_d;
`ifdef AQ_GEMAC_RX_STRIP_FCS_EN
            dl_q         <= dl_d;
            fill_q       <= fill_d;
`endif
        end
    end

    assign DOUT           = dout_q;
    assign DOUT_VALID     = dout_valid_q;
    assign DOUT_SOP       = dout_sop_q;
    assign STATUS_VALID   = stat_valid_q;
    assign STATUS_LEN     = stat_len_q;
    assign STATUS_CRC_ERR = stat_crc_q;
    assign STATUS_RUNT    = stat_runt_q;
    assign STATUS_LONG    = stat_long_q;
    assign STATUS_RXER    = stat_rxer_q;
    assign STATUS_GOOD    = stat_good_q;

endmodule
`default_nettype wire
